// File: rtl/int_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : int_pipeline                                               |
// | Description : Four-stage (ID, EX, M, WB) in-order integer pipeline for a |
// |               subset of RV32I (ADD/SUB/XOR/OR/AND/SLT/SLTU, the matching |
// |               immediate forms, LUI and EBREAK).                          |
// |                                                                          |
// | Ports       : clk           rising-edge clock                            |
// |               rst           synchronous active-high reset                |
// |               instr_valid   instruction offered                          |
// |               instr[31:0]   RV32I encoding                               |
// |               instr_ready   instruction taken into ID this cycle         |
// |               retire_valid  WB record valid                              |
// |               retire_we     WB record writes the register file           |
// |               retire_rd     WB destination register field                |
// |               retire_data   WB result (0 when retire_we is low)          |
// |               halted        an EBREAK has reached WB                     |
// |               dbg_addr      debug register index                         |
// |               dbg_data      debug register value (combinational)        |
// |                                                                          |
// | Build macro : INT_PIPELINE_FORWARDING_EN -- bypass EX/M results into the |
// |               ID operands instead of stalling on read-after-write.       |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module int_pipeline #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            retire_valid,
  output logic            retire_we,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            halted,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int          RW          = $clog2(NREG);
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [6:0]  OPC_OP      = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI     = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_AND  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6
  } alu_op_e;

  // ---------------------------------------------------------------- state
  logic            id_valid_q, id_valid_d;
  logic [31:0]     id_instr_q, id_instr_d;

  logic            ex_valid_q, ex_valid_d;
  alu_op_e         ex_op_q, ex_op_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_we_q, ex_we_d;
  logic            ex_ebreak_q, ex_ebreak_d;

  logic            m_valid_q, m_valid_d;
  logic [XLEN-1:0] m_data_q, m_data_d;
  logic [4:0]      m_rd_q, m_rd_d;
  logic            m_we_q, m_we_d;
  logic            m_ebreak_q, m_ebreak_d;

  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;

  logic            halted_q, halted_d;
  logic            ebreak_seen_q, ebreak_seen_d;

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  // ---------------------------------------------------------------- wires
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [RW-1:0]   id_rs1, id_rs2;

  alu_op_e         dec_op;
  logic            dec_we;
  logic            dec_use_rs1;
  logic            dec_use_rs2;
  logic            dec_ebreak;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] opnd1, opnd2;

  logic [XLEN-1:0] ex_alu;
  logic            stall;
  logic            accept;

  // Register-file read with write-through from the instruction in WB, which
  // commits at the end of this cycle.
  function automatic logic [XLEN-1:0] read_port(input logic [RW-1:0] idx);
    if (idx == '0) begin
      return '0;
    end else if (wb_valid_q && wb_we_q && (wb_rd_q[RW-1:0] == idx)) begin
      return wb_data_q;
    end else begin
      return rf_q[idx];
    end
  endfunction

  function automatic logic ex_writes(input logic [RW-1:0] idx);
    return (idx != '0) && ex_valid_q && ex_we_q && (ex_rd_q[RW-1:0] == idx);
  endfunction

  function automatic logic m_writes(input logic [RW-1:0] idx);
    return (idx != '0) && m_valid_q && m_we_q && (m_rd_q[RW-1:0] == idx);
  endfunction

  // ---------------------------------------------------------------- ID decode
  assign id_opcode = id_instr_q[6:0];
  assign id_funct3 = id_instr_q[14:12];
  assign id_funct7 = id_instr_q[31:25];
  assign id_rs1    = id_instr_q[15 +: RW];
  assign id_rs2    = id_instr_q[20 +: RW];

  always_comb begin
    dec_op      = ALU_ADD;
    dec_we      = 1'b0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_ebreak  = (id_instr_q == EBREAK_INSN);
    dec_imm     = XLEN'($signed(id_instr_q[31:20]));
    case (id_opcode)
      OPC_OP: begin
        if (id_funct7 == 7'b0000000) begin
          dec_we = 1'b1;
          case (id_funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b110:  dec_op = ALU_OR;
            3'b111:  dec_op = ALU_AND;
            default: dec_we = 1'b0;
          endcase
        end else if ((id_funct7 == 7'b0100000) && (id_funct3 == 3'b000)) begin
          dec_we = 1'b1;
          dec_op = ALU_SUB;
        end
        dec_use_rs1 = dec_we;
        dec_use_rs2 = dec_we;
      end
      OPC_OP_IMM: begin
        dec_we = 1'b1;
        case (id_funct3)
          3'b000:  dec_op = ALU_ADD;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b110:  dec_op = ALU_OR;
          3'b111:  dec_op = ALU_AND;
          default: dec_we = 1'b0;
        endcase
        dec_use_rs1 = dec_we;
      end
      OPC_LUI: begin
        dec_we  = 1'b1;
        dec_op  = ALU_ADD;            // 0 + (imm << 12)
        dec_imm = XLEN'($signed({id_instr_q[31:12], 12'h000}));
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- operands / hazards
`ifdef INT_PIPELINE_FORWARDING_EN
  // Youngest producer wins: EX result, then M, then the register file.
  always_comb begin
    opnd1 = read_port(id_rs1);
    opnd2 = read_port(id_rs2);
    if (ex_writes(id_rs1)) begin
      opnd1 = ex_alu;
    end else if (m_writes(id_rs1)) begin
      opnd1 = m_data_q;
    end
    if (ex_writes(id_rs2)) begin
      opnd2 = ex_alu;
    end else if (m_writes(id_rs2)) begin
      opnd2 = m_data_q;
    end
  end
  assign stall = 1'b0;
`else
  assign opnd1 = read_port(id_rs1);
  assign opnd2 = read_port(id_rs2);
  // WB producers are covered by write-through, so only EX and M can block.
  assign stall = id_valid_q &&
                 ((dec_use_rs1 && (ex_writes(id_rs1) || m_writes(id_rs1))) ||
                  (dec_use_rs2 && (ex_writes(id_rs2) || m_writes(id_rs2))));
`endif

  assign instr_ready = !stall && !halted_q && !ebreak_seen_q;
  assign accept      = instr_valid && instr_ready;

  // ---------------------------------------------------------------- EX ALU
  always_comb begin
    ex_alu = '0;
    case (ex_op_q)
      ALU_ADD:  ex_alu = ex_a_q + ex_b_q;
      ALU_SUB:  ex_alu = ex_a_q - ex_b_q;
      ALU_XOR:  ex_alu = ex_a_q ^ ex_b_q;
      ALU_OR:   ex_alu = ex_a_q | ex_b_q;
      ALU_AND:  ex_alu = ex_a_q & ex_b_q;
      ALU_SLT:  ex_alu = XLEN'($signed(ex_a_q) < $signed(ex_b_q));
      ALU_SLTU: ex_alu = XLEN'(ex_a_q < ex_b_q);
      default:  ex_alu = '0;
    endcase
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // ID holds while stalled; otherwise it takes the new instruction or empties.
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    if (!stall) begin
      id_valid_d = accept;
      if (accept) begin
        id_instr_d = instr;
      end
    end

    // A stall turns the ID->EX transfer into a bubble.
    ex_valid_d  = id_valid_q && !stall;
    ex_op_d     = dec_op;
    ex_a_d      = dec_use_rs1 ? opnd1 : '0;
    ex_b_d      = dec_use_rs2 ? opnd2 : dec_imm;
    ex_rd_d     = id_instr_q[11:7];
    ex_we_d     = dec_we;
    ex_ebreak_d = dec_ebreak;

    m_valid_d   = ex_valid_q;
    m_data_d    = ex_we_q ? ex_alu : '0;
    m_rd_d      = ex_rd_q;
    m_we_d      = ex_we_q;
    m_ebreak_d  = ex_ebreak_q;

    wb_valid_d  = m_valid_q;
    wb_data_d   = m_data_q;
    wb_rd_d     = m_rd_q;
    wb_we_d     = m_we_q;

    // halted rises together with the EBREAK's WB record.
    halted_d      = halted_q || (m_valid_q && m_ebreak_q);
    ebreak_seen_d = ebreak_seen_q || (accept && (instr == EBREAK_INSN));

    rf_d = rf_q;
    if (wb_valid_q && wb_we_q && (wb_rd_q[RW-1:0] != '0)) begin
      rf_d[wb_rd_q[RW-1:0]] = wb_data_q;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      ex_valid_q    <= 1'b0;
      ex_op_q       <= ALU_ADD;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_rd_q       <= '0;
      ex_we_q       <= 1'b0;
      ex_ebreak_q   <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_rd_q        <= '0;
      m_we_q        <= 1'b0;
      m_ebreak_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_we_q       <= 1'b0;
      halted_q      <= 1'b0;
      ebreak_seen_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      ex_rd_q       <= ex_rd_d;
      ex_we_q       <= ex_we_d;
      ex_ebreak_q   <= ex_ebreak_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_rd_q        <= m_rd_d;
      m_we_q        <= m_we_d;
      m_ebreak_q    <= m_ebreak_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_we_q       <= wb_we_d;
      halted_q      <= halted_d;
      ebreak_seen_q <= ebreak_seen_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign retire_valid = wb_valid_q;
  assign retire_we    = wb_we_q;
  assign retire_rd    = wb_rd_q;
  assign retire_data  = wb_data_q;
  assign halted       = halted_q;
  assign dbg_data     = read_port(dbg_addr[RW-1:0]);

endmodule
`default_nettype wire

// File: tb/tb_int_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_int_pipeline                                            |
// | Description : Self-checking bench for int_pipeline. An ISA-level model   |
// |               executes each accepted instruction in program order and   |
// |               queues the expected WB record; a negedge monitor compares |
// |               every retirement against it.                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_int_pipeline;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic            retire_valid;
  logic            retire_we;
  logic [4:0]      retire_rd;
  logic [XLEN-1:0] retire_data;
  logic            halted;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ebreak;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_cyc[$];
  int          ret_cyc[$];
  logic [31:0] mreg [32];
  logic        model_halted;

  int_pipeline #(.XLEN(XLEN), .NREG(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .retire_valid (retire_valid),
    .retire_we    (retire_we),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .halted       (halted),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  // ---------------------------------------------------------------- ISA model
  function automatic void model_exec(input logic [31:0] ins, output exp_t e);
    logic [31:0] a, b, imm;
    logic [2:0]  f3;
    logic [6:0]  f7, opc;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = mreg[ins[19:15]];
    b   = mreg[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    e.we     = 1'b0;
    e.rd     = ins[11:7];
    e.data   = 32'd0;
    e.ebreak = (ins == 32'h0010_0073);
    if (opc == 7'h13) b = imm;
    if ((opc == 7'h33 && f7 == 7'h00) || opc == 7'h13) begin
      e.we = 1'b1;
      case (f3)
        3'd0:    e.data = a + b;
        3'd2:    e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3:    e.data = (a < b) ? 32'd1 : 32'd0;
        3'd4:    e.data = a ^ b;
        3'd6:    e.data = a | b;
        3'd7:    e.data = a & b;
        default: e.we = 1'b0;
      endcase
    end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      e.we   = 1'b1;
      e.data = a - b;
    end else if (opc == 7'h37) begin
      e.we   = 1'b1;
      e.data = {ins[31:12], 12'h000};
    end
    if (e.we && e.rd != 5'd0) mreg[e.rd] = e.data;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    if (retire_valid === 1'b1) begin
      ret_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_retire: got rd=%0d data=%h, required no retire", retire_rd, retire_data);
      end else begin
        e = exp_q.pop_front();
        if ({retire_we, retire_rd, retire_data} !== {e.we, e.rd, e.data}) begin
          failures++;
          $display("FAIL retire_record: got we=%b rd=%0d data=%h, required we=%b rd=%0d data=%h",
                   retire_we, retire_rd, retire_data, e.we, e.rd, e.data);
        end
        if (e.ebreak) begin
          model_halted = 1'b1;
          checks++;
          if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halted_at_wb: got %b, required 1", halted);
          end
        end
      end
    end
    if (rst === 1'b1) begin
      exp_q.delete();
      acc_cyc.delete();
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      model_halted = 1'b0;
    end else if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      model_exec(instr, e);
      exp_q.push_back(e);
      acc_cyc.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ret_cyc.delete();
  endtask

  task automatic send(input logic [31:0] ins);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    instr_valid = 1'b1;
    instr = ins;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = instr_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: instr %h not accepted in %0d cycles, required acceptance", ins, n);
    end
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    instr_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_ready !== 1'b1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ready=%b halted=%b, required ready=1 halted=0", instr_ready, halted);
    end
    checks++;
    if ({retire_valid, retire_we, retire_rd, retire_data} !== '0) begin
      failures++;
      $display("FAIL reset_retire: got v=%b we=%b rd=%0d data=%h, required all 0",
               retire_valid, retire_we, retire_rd, retire_data);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg x%0d: got %h, required 0", r, dbg_data);
      end
    end
  endtask

  task automatic test_raw_chain();
    int exp_gap;
`ifdef INT_PIPELINE_FORWARDING_EN
    exp_gap = 1;
`else
    exp_gap = 3;
`endif
    do_reset();
    send(enc_i(3'd0, 5'd1, 5'd0, 12'd5));
    send(enc_i(3'd0, 5'd2, 5'd0, 12'd7));
    send(enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2));
    wait_drain();
    dbg_addr = 5'd3; #1;
    checks++;
    if (dbg_data !== 32'd12) begin
      failures++;
      $display("FAIL raw_chain_x3: got %0d, required 12", dbg_data);
    end
    checks++;
    if (ret_cyc.size() != 3 || acc_cyc.size() != 3) begin
      failures++;
      $display("FAIL raw_chain_count: got %0d retires, required 3", ret_cyc.size());
    end else begin
      checks++;
      if (ret_cyc[0] - acc_cyc[0] != 4) begin
        failures++;
        $display("FAIL raw_chain_latency: got %0d, required 4", ret_cyc[0] - acc_cyc[0]);
      end
      checks++;
      if (ret_cyc[1] - ret_cyc[0] != 1 || ret_cyc[2] - ret_cyc[1] != exp_gap) begin
        failures++;
        $display("FAIL raw_chain_timing: got gaps %0d,%0d, required 1,%0d",
                 ret_cyc[1] - ret_cyc[0], ret_cyc[2] - ret_cyc[1], exp_gap);
      end
    end
  endtask

  task automatic test_x0();
    do_reset();
    send(enc_i(3'd0, 5'd4, 5'd0, 12'd5));
    send(enc_i(3'd0, 5'd0, 5'd0, 12'd9));
    send(enc_r(7'h00, 3'd0, 5'd4, 5'd0, 5'd0));
    wait_drain();
    dbg_addr = 5'd0; #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      failures++;
      $display("FAIL x0_stays_zero: got %h, required 0", dbg_data);
    end
    dbg_addr = 5'd4; #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      failures++;
      $display("FAIL x0_add_x4: got %h, required 0", dbg_data);
    end
  endtask

  task automatic test_compare();
    do_reset();
    send(enc_lui(5'd5, 20'h80000));
    send(enc_i(3'd0, 5'd6, 5'd0, 12'hFFF));
    send(enc_r(7'h00, 3'd3, 5'd7, 5'd5, 5'd6));
    send(enc_r(7'h00, 3'd2, 5'd8, 5'd5, 5'd6));
    send(enc_r(7'h20, 3'd0, 5'd9, 5'd0, 5'd6));
    wait_drain();
    for (int r = 7; r <= 9; r++) begin
      dbg_addr = 5'(r); #1;
      checks++;
      if (dbg_data !== 32'd1) begin
        failures++;
        $display("FAIL compare_x%0d: got %h, required 1", r, dbg_data);
      end
    end
    dbg_addr = 5'd5; #1;
    checks++;
    if (dbg_data !== 32'h8000_0000) begin
      failures++;
      $display("FAIL compare_lui: got %h, required 80000000", dbg_data);
    end
  endtask

  task automatic test_ebreak();
    logic seen_ready;
    do_reset();
    send(enc_i(3'd0, 5'd1, 5'd0, 12'd1));
    send(32'h0010_0073);
    instr = enc_i(3'd0, 5'd2, 5'd0, 12'd2);
    instr_valid = 1'b1;
    seen_ready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (instr_ready !== 1'b0) seen_ready = 1'b1;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (seen_ready !== 1'b0) begin
      failures++;
      $display("FAIL ebreak_ready: got ready=1 after EBREAK, required 0");
    end
    wait_drain();
    idle(3);
    checks++;
    if (halted !== 1'b1 || model_halted !== 1'b1) begin
      failures++;
      $display("FAIL ebreak_halted: got %b, required 1", halted);
    end
    dbg_addr = 5'd1; #1;
    checks++;
    if (dbg_data !== 32'd1) begin
      failures++;
      $display("FAIL ebreak_x1: got %h, required 1", dbg_data);
    end
    dbg_addr = 5'd2; #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      failures++;
      $display("FAIL ebreak_x2: got %h, required 0", dbg_data);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    send(enc_i(3'd0, 5'd1, 5'd0, 12'd11));
    send(enc_i(3'd0, 5'd2, 5'd0, 12'd12));
    send(enc_i(3'd0, 5'd3, 5'd0, 12'd13));
    instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready: got %b, required 1", instr_ready);
    end
    idle(6);
    checks++;
    if (ret_cyc.size() != 0) begin
      failures++;
      $display("FAIL midrst_no_retire: got %0d retires, required 0", ret_cyc.size());
    end
    for (int r = 1; r <= 3; r++) begin
      dbg_addr = 5'(r); #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        failures++;
        $display("FAIL midrst_reg x%0d: got %h, required 0", r, dbg_data);
      end
    end
    send(enc_i(3'd0, 5'd1, 5'd0, 12'd3));
    wait_drain();
    checks++;
    if (ret_cyc.size() != 1 || acc_cyc.size() != 1) begin
      failures++;
      $display("FAIL midrst_count: got %0d retires, required 1", ret_cyc.size());
    end else if (ret_cyc[0] - acc_cyc[0] != 4) begin
      failures++;
      $display("FAIL midrst_latency: got %0d, required 4", ret_cyc[0] - acc_cyc[0]);
    end
    dbg_addr = 5'd1; #1;
    checks++;
    if (dbg_data !== 32'd3) begin
      failures++;
      $display("FAIL midrst_x1: got %h, required 3", dbg_data);
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    send(enc_i(3'd0, 5'd1, 5'd0, 12'd1));
    idle(2);
    send(enc_i(3'd0, 5'd1, 5'd1, 12'd1));
    wait_drain();
    idle(4);
    checks++;
    if (ret_cyc.size() != 2 || acc_cyc.size() != 2) begin
      failures++;
      $display("FAIL bubbles_count: got %0d retires, required 2", ret_cyc.size());
    end else if (ret_cyc[1] - acc_cyc[1] != 4) begin
      failures++;
      $display("FAIL bubbles_latency: got %0d, required 4", ret_cyc[1] - acc_cyc[1]);
    end
    dbg_addr = 5'd1; #1;
    checks++;
    if (dbg_data !== 32'd2) begin
      failures++;
      $display("FAIL bubbles_x1: got %h, required 2", dbg_data);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [6];
    logic [31:0] ins;
    logic [4:0]  rd, rs1, rs2;
    int          k;
    f3s = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    do_reset();
    for (int n = 0; n < 300; n++) begin
      k   = $urandom_range(9, 0);
      rd  = 5'($urandom_range(7, 0));
      rs1 = 5'($urandom_range(7, 0));
      rs2 = 5'($urandom_range(7, 0));
      case (k)
        0, 1, 2: ins = enc_r(7'h00, f3s[$urandom_range(5, 0)], rd, rs1, rs2);
        3:       ins = enc_r(7'h20, 3'd0, rd, rs1, rs2);
        4, 5, 6: ins = enc_i(f3s[$urandom_range(5, 0)], rd, rs1, 12'($urandom));
        7:       ins = enc_lui(rd, 20'($urandom));
        8:       ins = enc_r(7'h00, 3'd1, rd, rs1, rs2);
        default: ins = {12'($urandom), rs1, 3'd2, rd, 7'h03};
      endcase
      send(ins);
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
    end
    wait_drain();
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r); #1;
      checks++;
      if (dbg_data !== mreg[r]) begin
        failures++;
        $display("FAIL random_reg x%0d: got %h, required %h", r, dbg_data, mreg[r]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr        = 32'd0;
    dbg_addr     = 5'd0;
    model_halted = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    test_reset();
    test_raw_chain();
    test_x0();
    test_compare();
    test_ebreak();
    test_reset_midflight();
    test_bubbles();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
